ysyx_25040111_axi_sram: RTL and testbench

AXI4 slave (responder) backed by an on-chip word-addressed SRAM. It is the far end of the core's `io_master_*` port. In non-SoC simulation it serves icache burst refills and LSU single-beat loads and stores. Supported: INCR and FIXED bursts up to 256 beats, 4-bit ID echo, byte strobes, SLVERR/DECERR responses.

---
 rtl/ysyx_25040111_axi_sram_pkg.sv | 28 ++
 rtl/ysyx_25040111_sram_bank.sv | 27 ++
 rtl/ysyx_25040111_axi_sram.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_axi_sram.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_axi_sram_pkg.sv
// Shared encodings for the AXI4 SRAM responder:
// burst types, response codes, FSM states, response merge helper.
package ysyx_25040111_axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WD   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // DECERR > SLVERR > OKAY matches numeric order of the codes.
  function automatic logic [1:0] resp_max(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ysyx_25040111_sram_bank.sv
// Word SRAM: WORDS x 32, per-byte write enable, registered read.
// Ports: clk, re, we[3:0], addr, wdata in; rdata out (held when re=0).
module ysyx_25040111_sram_bank #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_25040111_axi_sram.sv
// AXI4 slave over on-chip SRAM; one transaction at a time, INCR/FIXED.
// Ports: clock, reset (sync, active-low), s_aw*/s_w*/s_b*/s_ar*/s_r*.
// Option YSYX_25040111_SRAM_LFSR_DELAY_EN: LFSR-random 0-7 cycle stalls.
module ysyx_25040111_axi_sram
  import ysyx_25040111_axi_sram_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        s_awready,
  input  logic        s_awvalid,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  output logic        s_wready,
  input  logic        s_wvalid,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  input  logic        s_bready,
  output logic        s_bvalid,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  output logic        s_arready,
  input  logic        s_arvalid,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  input  logic        s_rready,
  output logic        s_rvalid,
  output logic [1:0]  s_rresp,
  output logic [31:0] s_rdata,
  output logic        s_rlast,
  output logic [3:0]  s_rid
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Every size up to a word is served the same way.
  logic unused_sz;
  assign unused_sz = ^{s_arsize, s_awsize};

  function automatic logic [1:0] beat_resp(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [31:0] off;
    off = a - BASE_ADDR;
    if (b != BURST_INCR && b != BURST_FIXED) return RESP_SLVERR;
    if (a < BASE_ADDR) return RESP_DECERR;
    if (off >= (32'(MEM_WORDS) << 2)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    return (b == BURST_INCR) ? a + 32'd4 : a;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  id_q, id_d;
  logic [1:0]  burst_q, burst_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        rmask_q, rmask_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        pend_q, pend_d;
  logic [2:0]  stall_q, stall_d;
  logic [2:0]  dly;

`ifdef YSYX_25040111_SRAM_LFSR_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign dly = lfsr_q[2:0];
  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign dly = 3'd0;
`endif

  logic          issue;
  logic [31:0]   iss_addr;
  logic [7:0]    iss_cnt;
  logic [7:0]    iss_len;
  logic [1:0]    iss_burst;
  logic          bank_re;
  logic [3:0]    bank_we;
  logic [AW-1:0] bank_idx;
  logic [31:0]   bank_rdata;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    burst_d   = burst_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rmask_d   = rmask_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pend_d    = pend_q;
    stall_d   = stall_q;
    issue     = 1'b0;
    iss_addr  = addr_q;
    iss_cnt   = cnt_q;
    iss_len   = len_q;
    iss_burst = burst_q;
    bank_re   = 1'b0;
    bank_we   = 4'b0;
    bank_idx  = idx_of(addr_q);

    unique case (state_q)
      ST_IDLE: begin
        if (s_arvalid) begin
          addr_d    = s_araddr;
          len_d     = s_arlen;
          id_d      = s_arid;
          burst_d   = s_arburst;
          cnt_d     = 8'd0;
          state_d   = ST_RD;
          iss_addr  = s_araddr;
          iss_cnt   = 8'd0;
          iss_len   = s_arlen;
          iss_burst = s_arburst;
          if (dly == 3'd0) begin
            issue = 1'b1;
          end else begin
            pend_d  = 1'b1;
            stall_d = dly - 3'd1;
          end
        end else if (s_awvalid) begin
          addr_d  = s_awaddr;
          len_d   = s_awlen;
          id_d    = s_awid;
          burst_d = s_awburst;
          cnt_d   = 8'd0;
          bresp_d = RESP_OKAY;
          state_d = ST_WD;
          if (dly == 3'd0) begin
            wready_d = 1'b1;
          end else begin
            pend_d  = 1'b1;
            stall_d = dly - 3'd1;
          end
        end
      end
      ST_RD: begin
        if (rvalid_q && s_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end else if (dly == 3'd0) begin
            issue = 1'b1;
          end else begin
            rvalid_d = 1'b0;
            pend_d   = 1'b1;
            stall_d  = dly - 3'd1;
          end
        end else if (pend_q) begin
          if (stall_q == 3'd0) begin
            issue  = 1'b1;
            pend_d = 1'b0;
          end else begin
            stall_d = stall_q - 3'd1;
          end
        end
      end
      ST_WD: begin
        if (wready_q && s_wvalid) begin
          if (beat_resp(addr_q, burst_q) == RESP_OKAY) begin
            bank_we = s_wstrb;
          end
          bresp_d = resp_max(bresp_q, beat_resp(addr_q, burst_q));
          // wlast must coincide exactly with beat number len
          if (s_wlast != (cnt_q == len_q)) begin
            bresp_d = resp_max(bresp_d, RESP_SLVERR);
          end
          addr_d = next_addr(addr_q, burst_q);
          cnt_d  = cnt_q + 8'd1;
          if (s_wlast) begin
            wready_d = 1'b0;
            state_d  = ST_WB;
            if (dly == 3'd0) begin
              bvalid_d = 1'b1;
            end else begin
              pend_d  = 1'b1;
              stall_d = dly - 3'd1;
            end
          end else if (dly != 3'd0) begin
            wready_d = 1'b0;
            pend_d   = 1'b1;
            stall_d  = dly - 3'd1;
          end
        end else if (pend_q) begin
          if (stall_q == 3'd0) begin
            wready_d = 1'b1;
            pend_d   = 1'b0;
          end else begin
            stall_d = stall_q - 3'd1;
          end
        end
      end
      ST_WB: begin
        if (bvalid_q && s_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (pend_q) begin
          if (stall_q == 3'd0) begin
            bvalid_d = 1'b1;
            pend_d   = 1'b0;
          end else begin
            stall_d = stall_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Launch one R beat: SRAM read now, data visible next cycle.
    if (issue) begin
      rvalid_d = 1'b1;
      rresp_d  = beat_resp(iss_addr, iss_burst);
      rmask_d  = (rresp_d != RESP_OKAY);
      rlast_d  = (iss_cnt == iss_len);
      addr_d   = next_addr(iss_addr, iss_burst);
      cnt_d    = iss_cnt + 8'd1;
      bank_re  = ~rmask_d;
      bank_idx = idx_of(iss_addr);
    end

    if (!reset) begin
      bank_re = 1'b0;
      bank_we = 4'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      id_q     <= 4'd0;
      burst_q  <= BURST_INCR;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rmask_q  <= 1'b1;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      pend_q   <= 1'b0;
      stall_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rmask_q  <= rmask_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      pend_q   <= pend_d;
      stall_q  <= stall_d;
    end
  end

  ysyx_25040111_sram_bank #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_bank (
    .clk   (clock),
    .re    (bank_re),
    .we    (bank_we),
    .addr  (bank_idx),
    .wdata (s_wdata),
    .rdata (bank_rdata)
  );

  assign s_arready = reset && (state_q == ST_IDLE);
  assign s_awready = reset && (state_q == ST_IDLE) && !s_arvalid;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_bid     = id_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;
  assign s_rid     = id_q;
  assign s_rdata   = rmask_q ? 32'd0 : bank_rdata;

endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// Directed bench for ysyx_25040111_axi_sram with a reference memory
// and expected-response queues.
module tb_ysyx_25040111_axi_sram;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TMO  = 64;

  logic        clock, reset;
  logic        s_awready, s_awvalid;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wready, s_wvalid;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bready, s_bvalid;
  logic [1:0]  s_bresp;
  logic [3:0]  s_bid;
  logic        s_arready, s_arvalid;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rready, s_rvalid;
  logic [1:0]  s_rresp;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic [3:0]  s_rid;

  ysyx_25040111_axi_sram #(
    .MEM_WORDS (MW),
    .BASE_ADDR (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s_awready (s_awready),
    .s_awvalid (s_awvalid),
    .s_awaddr  (s_awaddr),
    .s_awid    (s_awid),
    .s_awlen   (s_awlen),
    .s_awsize  (s_awsize),
    .s_awburst (s_awburst),
    .s_wready  (s_wready),
    .s_wvalid  (s_wvalid),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_bready  (s_bready),
    .s_bvalid  (s_bvalid),
    .s_bresp   (s_bresp),
    .s_bid     (s_bid),
    .s_arready (s_arready),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arid    (s_arid),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_rready  (s_rready),
    .s_rvalid  (s_rvalid),
    .s_rresp   (s_rresp),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .s_rid     (s_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [MW];
  logic [38:0] rexp_q [$];
  logic [5:0]  bexp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a,
                                          input logic [1:0] b);
    if (b > 2'b01) return 2'b10;
    if (a < BASE) return 2'b11;
    if (((a - BASE) >> 2) >= MW) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a,
                                           input logic [1:0] b);
    logic [31:0] w;
    if (exp_resp(a, b) != 2'b00) return 32'd0;
    w = (a - BASE) >> 2;
    return model[w[5:0]];
  endfunction

  function automatic logic [31:0] beat_a(input logic [31:0] a,
                                         input logic [1:0] b,
                                         input int i);
    return (b == 2'b01) ? a + 32'(4 * i) : a;
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [3:0] id,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] strb, input logic [31:0] seed,
                    input int last_at);
    logic [1:0]  er;
    logic [31:0] a, d, w;
    int n;
    er = 2'b00;
    s_awvalid = 1'b1;
    s_awaddr  = addr;
    s_awid    = id;
    s_awlen   = len;
    s_awburst = burst;
    n = 0;
    while (s_awready !== 1'b1 && n < TMO) begin
      @(negedge clock);
      n++;
    end
    chk("aw_tmo", 64'(n < TMO), 64'd1);
    @(negedge clock);
    s_awvalid = 1'b0;
    chk("w_ready_lat", 64'(s_wready), 64'd1);
    for (int i = 0; i <= last_at; i++) begin
      a = beat_a(addr, burst, i);
      d = seed + 32'(i) * 32'h0101_0101;
      s_wvalid = 1'b1;
      s_wdata  = d;
      s_wstrb  = strb;
      s_wlast  = (i == last_at);
      n = 0;
      while (s_wready !== 1'b1 && n < TMO) begin
        @(negedge clock);
        n++;
      end
      @(negedge clock);
      if (exp_resp(a, burst) > er) er = exp_resp(a, burst);
      if (exp_resp(a, burst) == 2'b00) begin
        w = (a - BASE) >> 2;
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[w[5:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    if (last_at != int'(len) && er < 2'b10) er = 2'b10;
    bexp_q.push_back({id, er});
    chk("b_lat", 64'(s_bvalid), 64'd1);
    s_bready = 1'b1;
    n = 0;
    while (s_bvalid !== 1'b1 && n < TMO) begin
      @(negedge clock);
      n++;
    end
    chk("b_resp", 64'({s_bid, s_bresp}), 64'(bexp_q.pop_front()));
    @(negedge clock);
    s_bready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr,
                    input logic [3:0] id, input logic [7:0] len,
                    input logic [1:0] burst);
    logic [31:0] a;
    int n, stalls;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_a(addr, burst, i);
      rexp_q.push_back({id, exp_resp(a, burst), i == int'(len),
                        exp_data(a, burst)});
    end
    s_rready  = 1'b1;
    s_arvalid = 1'b1;
    s_araddr  = addr;
    s_arid    = id;
    s_arlen   = len;
    s_arburst = burst;
    n = 0;
    while (s_arready !== 1'b1 && n < TMO) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    s_arvalid = 1'b0;
    chk({tag, "_lat"}, 64'(s_rvalid), 64'd1);
    stalls = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (s_rvalid !== 1'b1 && n < TMO) begin
        @(negedge clock);
        n++;
        stalls++;
      end
      chk(tag, 64'({s_rid, s_rresp, s_rlast, s_rdata}),
          64'(rexp_q.pop_front()));
      @(negedge clock);
    end
    chk({tag, "_stalls"}, 64'(stalls), 64'd0);
    s_rready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0;
    s_awsize = 3'd2; s_awburst = 2'b01;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0;
    s_arsize = 3'd2; s_arburst = 2'b01;
    s_rready = 0;
    repeat (3) @(negedge clock);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    reset = 1'b1;
    #1;
    chk("idle_arready", 64'(s_arready), 64'd1);
    chk("idle_awready", 64'(s_awready), 64'd1);
    chk("rst_rout", 64'({s_rdata, s_rresp, s_rlast, s_rid}), 64'd0);
    chk("rst_bout", 64'({s_bresp, s_bid}), 64'd0);
    @(negedge clock);

    wr(BASE, 4'd1, 8'd15, 2'b01, 4'hF, 32'h1000_0000, 15);
    wr(BASE, 4'd2, 8'd0, 2'b01, 4'hF, 32'hDEAD_BEEF, 0);
    rd("single", BASE, 4'd3, 8'd0, 2'b01);
    rd("burst", BASE + 32'h10, 4'd4, 8'd3, 2'b01);

    wr(BASE + 32'h8, 4'd5, 8'd0, 2'b01, 4'hF, 32'hFFFF_FFFF, 0);
    wr(BASE + 32'h8, 4'd6, 8'd0, 2'b01, 4'b0101, 32'h1122_3344, 0);
    rd("strobe", BASE + 32'h8, 4'd7, 8'd0, 2'b01);

    rd("oor_rd", 32'h7FFF_FFFC, 4'd1, 8'd0, 2'b01);
    wr(BASE + 32'(4 * MW), 4'd9, 8'd0, 2'b01, 4'hF, 32'h5555_AAAA, 0);
    rd("oor_keep", BASE, 4'd2, 8'd0, 2'b01);

    rd("fixed", BASE + 32'h14, 4'd8, 8'd2, 2'b00);
    rd("wrap", BASE + 32'h8, 4'd7, 8'd1, 2'b10);
    wr(BASE + 32'h28, 4'hA, 8'd3, 2'b01, 4'hF, 32'hA0A0_0000, 1);
    wr(BASE + 32'h38, 4'hB, 8'd0, 2'b01, 4'hF, 32'hB0B0_0000, 1);
    rd("wlast_chk", BASE + 32'h28, 4'hC, 8'd5, 2'b01);

    // both address valids together, R stalled by the master
    s_rready  = 1'b0;
    s_arvalid = 1'b1; s_araddr = BASE + 32'h20; s_arid = 4'd5;
    s_arlen   = 8'd1; s_arburst = 2'b01;
    s_awvalid = 1'b1; s_awaddr = BASE + 32'h30; s_awid = 4'd6;
    s_awlen   = 8'd0; s_awburst = 2'b01;
    rexp_q.push_back({4'd5, 2'b00, 1'b0, model[8]});
    rexp_q.push_back({4'd5, 2'b00, 1'b1, model[9]});
    #1;
    chk("prio_ar", 64'(s_arready), 64'd1);
    chk("prio_aw", 64'(s_awready), 64'd0);
    @(negedge clock);
    s_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(s_rvalid), 64'd1);
      chk("bp_beat", 64'({s_rid, s_rresp, s_rlast, s_rdata}),
          64'(rexp_q[0]));
      chk("bp_aw", 64'(s_awready), 64'd0);
      @(negedge clock);
    end
    s_rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_pop", 64'({s_rid, s_rresp, s_rlast, s_rdata}),
          64'(rexp_q.pop_front()));
      @(negedge clock);
    end
    s_rready = 1'b0;
    chk("aw_after_r", 64'(s_awready), 64'd1);
    @(negedge clock);
    s_awvalid = 1'b0;
    chk("bp_wready", 64'(s_wready), 64'd1);
    s_wvalid = 1'b1; s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF;
    s_wlast = 1'b1;
    model[12] = 32'hCAFE_0001;
    bexp_q.push_back({4'd6, 2'b00});
    @(negedge clock);
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("bp_bvalid", 64'(s_bvalid), 64'd1);
    s_bready = 1'b1;
    chk("bp_bresp", 64'({s_bid, s_bresp}), 64'(bexp_q.pop_front()));
    @(negedge clock);
    s_bready = 1'b0;
    rd("raw", BASE + 32'h30, 4'd2, 8'd0, 2'b01);

    // reset while beat 2 of an 8-beat read is on the bus
    for (int i = 0; i < 8; i++)
      rexp_q.push_back({4'd9, 2'b00, i == 7, model[i]});
    s_rready = 1'b1;
    s_arvalid = 1'b1; s_araddr = BASE; s_arid = 4'd9;
    s_arlen = 8'd7; s_arburst = 2'b01;
    @(negedge clock);
    s_arvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("pre_rst", 64'({s_rid, s_rresp, s_rlast, s_rdata}),
          64'(rexp_q.pop_front()));
      @(negedge clock);
    end
    chk("beat2_valid", 64'(s_rvalid), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
    s_rready = 1'b0;
    rexp_q.delete();
    reset = 1'b1;
    #1;
    chk("mid_rst_idle", 64'(s_arready), 64'd1);
    @(negedge clock);
    rd("post_rst", BASE + 32'h24, 4'd3, 8'd1, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
